conv_stream_ctrl: RTL and testbench
===================================

CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 Parameter M, default 480: frame rows.
REQ-002 Parameter N, default 640: frame columns.
REQ-003 Parameter K, default 3: kernel size; legal range 1 to min(M,N).
REQ-004 Parameter LAT, default 8: datapath result latency in pipe_en advances; legal values are LAT >= 1.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and reset_n.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  single-cycle pulse that arms one frame.
REQ-009 abort  in  1  synchronous frame cancel.
REQ-010 s_valid  in  1  upstream pixel valid.
REQ-011 s_ready  out  1  pixel accepted when s_valid and s_ready are both high.
REQ-012 pipe_en  out  1  clock-enable to the convolution datapath; high means advance one pixel.
REQ-013 m_valid  out  1  datapath output holds a valid convolution result.
REQ-014 m_ready  in  1  downstream accepts the result.
REQ-015 m_last  out  1  marks the final result of the frame.
REQ-016 row  out  10  row of the next pixel to accept.
REQ-017 col  out  10  column of the next pixel to accept.
REQ-018 busy  out  1  high in RUN or FLUSH.
REQ-019 done  out  1  one-cycle frame-complete pulse.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RUN, FLUSH and DONE.
REQ-021 IDLE->RUN on start; start SHALL be ignored in any state other than IDLE.
REQ-022 RUN->FLUSH on acceptance of pixel (row M-1, col N-1).
REQ-023 FLUSH->DONE on the m_valid & m_ready & m_last handshake.
REQ-024 DONE->IDLE unconditionally after one cycle; done SHALL be high only in DONE.
REQ-025 s_ready SHALL be (state==RUN) & (m_ready | ~m_valid).
REQ-026 pipe_en SHALL be s_valid & s_ready in RUN, (m_ready | ~m_valid) in FLUSH, and 0 in IDLE and DONE.
REQ-027 col/row advance on each accept: col increments; when col==N-1, col wraps to 0 and row increments.
REQ-028 row/col SHALL be cleared to 0 on IDLE->RUN.
REQ-029 Window-valid flag wv for an accepted pixel = (row>=K-1) & (col>=K-1).
REQ-030 Window-last flag wl = (row==M-1) & (col==N-1).
REQ-031 wv and wl SHALL propagate through a LAT-deep shift register that shifts only when pipe_en is high.
REQ-032 Stage 0 SHALL load wv/wl on an accept and load 0 on a FLUSH advance.
REQ-033 m_valid SHALL equal wv at stage LAT-1, and m_last SHALL equal wl at stage LAT-1.
REQ-034 While m_valid=1 and m_ready=0, m_valid, m_last and the shift register SHALL hold, and pipe_en SHALL be 0.
REQ-035 Each frame SHALL produce exactly (M-K+1)*(N-K+1) m_valid handshakes, with m_last on the final one only.
REQ-036 abort in any state SHALL force IDLE on the next edge and clear the shift register, row and col; no done pulse results.
REQ-037 If abort and start are high in the same cycle, abort SHALL win.
REQ-038 s_valid gaps SHALL stall pipe_en without changing any counter or shift-register state.

Reset
REQ-039 While reset_n=0: state=IDLE; row, col and the shift register = 0; s_ready, pipe_en, m_valid, m_last, busy and done = 0.
REQ-040 Reset SHALL act immediately, not on the next clock edge, and SHALL apply mid-frame as well as at idle.
REQ-041 The first start after reset_n rises SHALL begin a clean frame.

Verification (M=4, N=5, K=3, LAT=2)
REQ-042 Continuous traffic: start, then s_valid=1 and m_ready=1 constantly -> 20 accepts and 6 m_valid beats. m_valid first goes high in the cycle after index 13 is accepted. m_last is on beat 6. done pulses once, in the cycle after the last handshake.
REQ-043 Backpressure: m_ready=0 for 5 cycles while m_valid=1 -> s_ready=0 and pipe_en=0 throughout; m_valid and m_last stable; no beats lost or duplicated.
REQ-044 Input gaps: s_valid toggled 1/0 throughout the frame -> pipe_en equals the accept count (20); beat count is still 6.
REQ-045 Abort in FLUSH with m_valid=1 -> next cycle state=IDLE, m_valid=0, busy=0; done never pulses.
REQ-046 Asynchronous reset: reset_n dropped at accept index 9 -> all outputs are 0 before the next edge. A new start yields a full 6-beat frame.
REQ-047 Start while busy, and the wrap at col=4: start asserted at row=1, col=4 is ignored, and the next accept gives row=2, col=0.

Source files
------------

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for a streaming KxK convolution datapath: tracks pixel position,
// gates the datapath clock-enable and tags results as window-valid / frame-last.
module conv_stream_ctrl #(
  parameter int unsigned M   = 480,
  parameter int unsigned N   = 640,
  parameter int unsigned K   = 3,
  parameter int unsigned LAT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        pipe_en,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] ROW_LAST  = CW'(M - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] WIN_FIRST = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic           room;
  logic           accept;
  logic           last_pix;
  logic           win_valid;
  logic           frame_arm;
  logic           sr_wv_in;
  logic           sr_wl_in;
  logic [LAT-1:0] wv_sr;
  logic [LAT-1:0] wl_sr;

  // The output stage can take a new result when it is empty or being drained.
  assign room      = m_ready | ~m_valid;
  assign accept    = s_valid & s_ready;
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign win_valid = (row >= WIN_FIRST) && (col >= WIN_FIRST);
  assign frame_arm = (state == IDLE) && start;

  // Only accepted pixels carry tags; flush advances push empty bubbles.
  assign sr_wv_in  = (state == RUN) & win_valid;
  assign sr_wl_in  = (state == RUN) & last_pix;

  assign m_valid   = wv_sr[LAT-1];
  assign m_last    = wl_sr[LAT-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state handshake decode.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    pipe_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        s_ready = room;
        pipe_en = s_valid & room;
        if (s_valid && room && last_pix) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        pipe_en = room;
        if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Raster position of the next pixel to accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (abort || frame_arm) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Tag pipeline mirroring the datapath latency; frozen whenever pipe_en is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wv_sr <= '0;
      wl_sr <= '0;
    end else if (abort || frame_arm) begin
      wv_sr <= '0;
      wl_sr <= '0;
    end else if (pipe_en) begin
      for (int unsigned i = 1; i < LAT; i++) begin
        wv_sr[i] <= wv_sr[i-1];
        wl_sr[i] <= wl_sr[i-1];
      end
      wv_sr[0] <= sr_wv_in;
      wl_sr[0] <= sr_wl_in;
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl at M=4, N=5, K=3, LAT=2.
module tb_conv_stream_ctrl;

  localparam int M       = 4;
  localparam int N       = 5;
  localparam int K       = 3;
  localparam int LAT     = 2;
  localparam int ACCEPTS = M * N;
  localparam int BEATS   = (M - K + 1) * (N - K + 1);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       s_valid;
  logic       s_ready;
  logic       pipe_en;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic [9:0] row;
  logic [9:0] col;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  conv_stream_ctrl #(.M(M), .N(N), .K(K), .LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .pipe_en (pipe_en),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .row     (row),
    .col     (col),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, int'(s_ready), 0);
    check({tag, "_pipe_en"}, int'(pipe_en), 0);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_last"},  int'(m_last),  0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_done"},    int'(done),    0);
    check({tag, "_row"},     int'(row),     0);
    check({tag, "_col"},     int'(col),     0);
  endtask

  // A result is consumed when it is handshaken while the datapath advances.
  always @(negedge clk) begin
    if (m_valid && m_ready && pipe_en) begin
      if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
      else                   check("beat_m_last", int'(m_last), int'(exp_q.pop_front()));
    end
  end

  // mode: 0 continuous, 1 backpressure, 2 input gaps, 3 start while busy,
  //       4 abort+start in FLUSH, 5 async reset at accept index 9
  task automatic run_frame(input int mode);
    int acc = 0, er = 0, ec = 0, pe_cnt = 0, bp_left = 0;
    bit bp_done = 0, st_done = 0, hs_prev = 0, fin = 0, stop = 0;
    for (int i = 0; i < BEATS; i++) exp_q.push_back(i == BEATS - 1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    abort   = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int cyc = 0; cyc < 300 && !fin && !stop; cyc++) begin
      s_valid = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
      m_ready = 1'b1;
      if (mode == 1 && acc == 14 && !bp_done) begin
        bp_left = 5;
        bp_done = 1'b1;
      end
      if (bp_left > 0) m_ready = 1'b0;
      if (mode == 3 && acc == 9 && !st_done) begin
        check("start_busy_row", int'(row), 1);
        check("start_busy_col", int'(col), 4);
        start   = 1'b1;
        s_valid = 1'b0;
        st_done = 1'b1;
      end
      if (mode == 4 && acc == ACCEPTS) begin
        abort   = 1'b1;
        start   = 1'b1;
        m_ready = 1'b0;
        stop    = 1'b1;
      end
      if (mode == 5 && acc == 9) begin
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_rst");
        stop = 1'b1;
      end else begin
        @(negedge clk);
        if (acc < ACCEPTS) begin
          check("row", int'(row), er);
          check("col", int'(col), ec);
          check("s_ready_run", int'(s_ready), int'(m_ready));
          check("pipe_en_run", int'(pipe_en), int'(s_valid & m_ready));
          if (pipe_en) pe_cnt++;
        end
        if (bp_left > 0) begin
          check("bp_m_valid", int'(m_valid), 1);
          check("bp_m_last", int'(m_last), 0);
          bp_left--;
        end
        if (mode == 4 && stop) begin
          check("abort_pre_m_valid", int'(m_valid), 1);
          check("abort_pre_busy", int'(busy), 1);
        end
        check("done_timing", int'(done), int'(hs_prev));
        hs_prev = m_valid & m_ready & m_last;
        if (done) fin = 1'b1;
        if (s_valid && s_ready) begin
          acc++;
          if (ec == N - 1) begin
            ec = 0;
            er++;
          end else begin
            ec++;
          end
        end
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
      end
    end
    if (mode == 4) begin
      check("abort_busy", int'(busy), 0);
      check("abort_m_valid", int'(m_valid), 0);
      check("abort_s_ready", int'(s_ready), 0);
      check("abort_row", int'(row), 0);
      check("abort_col", int'(col), 0);
      repeat (4) begin
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        check("abort_idle_busy", int'(busy), 0);
      end
      check("abort_beats_left", exp_q.size(), 2);
      exp_q.delete();
      @(posedge clk); #1;
    end else if (mode == 5) begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_beats_left", exp_q.size(), BEATS);
      exp_q.delete();
    end else begin
      check("frame_complete", int'(fin), 1);
      check("frame_accepts", acc, ACCEPTS);
      check("frame_beats", exp_q.size(), 0);
      if (mode == 2) check("gap_pipe_en", pe_cnt, ACCEPTS);
      @(negedge clk);
      check("post_done", int'(done), 0);
      check("post_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b1;
    abort   = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(4);
    run_frame(5);
    run_frame(0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
